// File: rtl/spi_tx_arbiter_if.sv
// Bus bundle between N word requesters, the arbiter and one SPI transmitter.
// The master modport is the arbiter's view; slave is the requester/transmitter side.
interface spi_tx_arbiter_if #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_NUM_REQ    = 4
);
    localparam int GW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;

    logic [P_NUM_REQ-1:0]              req_valid;
    logic [P_NUM_REQ*P_DATA_WIDTH-1:0] req_data;
    logic [P_NUM_REQ-1:0]              req_ready;
    logic                              tx_valid;
    logic [P_DATA_WIDTH-1:0]           tx_data;
    logic                              tx_ready;
    logic [GW-1:0]                     grant_id;
    logic                              busy;
    logic                              xfer_done;

    modport master (
        input  req_valid, req_data, tx_ready,
        output req_ready, tx_valid, tx_data, grant_id, busy, xfer_done
    );

    modport slave (
        output req_valid, req_data, tx_ready,
        input  req_ready, tx_valid, tx_data, grant_id, busy, xfer_done
    );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter feeding one SPI transmitter a word at a time (IDLE/SEND/WAIT).
// Define SPI_ARB_BURST_EN to let a granted requester send up to P_MAX_BURST words back to back.
module spi_tx_arbiter #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_NUM_REQ    = 4,
    parameter int P_MAX_BURST  = 4
) (
    input logic              clk_100,
    input logic              s_rst,
    spi_tx_arbiter_if.master bus
);
    localparam int GW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_e;

    state_e                  state_q;
    logic [P_NUM_REQ-1:0]    req_ready_q;
    logic                    tx_valid_q;
    logic [P_DATA_WIDTH-1:0] tx_data_q;
    logic [GW-1:0]           grant_q;
    logic [GW-1:0]           last_grant_q;
    logic                    busy_q;
    logic                    xfer_done_q;

    logic                    found_d;
    logic [GW-1:0]           sel_d;
    int                      idx;

`ifdef SPI_ARB_BURST_EN
    localparam int BW = $clog2(P_MAX_BURST + 1);
    logic [BW-1:0] burst_cnt_q;
`else
    localparam int unused_max_burst = P_MAX_BURST;
`endif

    // Search starts just past the last winner, so the previous grantee has lowest priority.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
        found_d = 1'b0;
        sel_d   = last_grant_q;
        idx     = 0;
        for (int k = 1; k <= P_NUM_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= P_NUM_REQ) idx = idx - P_NUM_REQ;
            if (!found_d && bus.req_valid[idx]) begin
                found_d = 1'b1;
                sel_d   = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            // NOTE: tx_data is reset too, so a dropped in-flight word never lingers on the bus.
            state_q      <= S_IDLE;
            req_ready_q  <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            grant_q      <= '0;
            last_grant_q <= GW'(P_NUM_REQ - 1);
            busy_q       <= 1'b0;
            xfer_done_q  <= 1'b0;
`ifdef SPI_ARB_BURST_EN
            burst_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            req_ready_q <= '0;
            xfer_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        tx_data_q    <= bus.req_data[sel_d*P_DATA_WIDTH +: P_DATA_WIDTH];
                        tx_valid_q   <= 1'b1;
                        req_ready_q  <= P_NUM_REQ'(1) << sel_d;
                        grant_q      <= sel_d;
                        last_grant_q <= sel_d;
                        busy_q       <= 1'b1;
                        state_q      <= S_SEND;
`ifdef SPI_ARB_BURST_EN
                        burst_cnt_q  <= BW'(1);
`endif
                    end
                end
                S_SEND: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.tx_ready) begin
                        xfer_done_q <= 1'b1;
`ifdef SPI_ARB_BURST_EN
                        if (bus.req_valid[grant_q] && (burst_cnt_q < BW'(P_MAX_BURST))) begin
                            tx_data_q   <= bus.req_data[grant_q*P_DATA_WIDTH +: P_DATA_WIDTH];
                            tx_valid_q  <= 1'b1;
                            req_ready_q <= P_NUM_REQ'(1) << grant_q;
                            burst_cnt_q <= burst_cnt_q + BW'(1);
                            state_q     <= S_SEND;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
`else
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = busy_q;
    assign bus.xfer_done = xfer_done_q;
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: vector table, multi-cycle sequences and a grant scoreboard.
// A simple transmitter model drops tx_ready for three cycles after each accepted word.
module tb_spi_tx_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;

    logic clk_100 = 1'b0;
    logic s_rst;

    spi_tx_arbiter_if #(.P_DATA_WIDTH(W), .P_NUM_REQ(N)) bus ();

    spi_tx_arbiter #(.P_DATA_WIDTH(W), .P_NUM_REQ(N), .P_MAX_BURST(4)) dut (
        .clk_100 (clk_100),
        .s_rst   (s_rst),
        .bus     (bus)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        int           gid;
        logic [W-1:0] data;
    } exp_t;

    typedef struct {
        logic [N-1:0]   valid;
        logic [N*W-1:0] data;
        int             gid;
        logic [W-1:0]   exp_data;
    } vec_t;

    exp_t         exp_q[$];
    int           checks    = 0;
    int           errors    = 0;
    int           grant_cnt = 0;
    int           xfer_cnt  = 0;
    logic [W-1:0] exp_tx_data = '0;
    bit           rdy_q     = 1'b1;
    bit           tx_stall  = 1'b0;
    bit           accepted  = 1'b0;
    int           shift_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int gid, input logic [W-1:0] d);
        exp_t e;
        e.gid  = gid;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor followed by the transmitter model, in one process so their order is fixed.
    always @(negedge clk_100) begin : mon
        exp_t e;
        if (bus.req_ready != '0) begin
            grant_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 64'(bus.req_ready), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("grant_ready", 64'(bus.req_ready), 64'(1) << e.gid);
                check("grant_id",    64'(bus.grant_id),  64'(e.gid));
                check("grant_data",  64'(bus.tx_data),   64'(e.data));
                check("grant_valid", 64'(bus.tx_valid),  64'(1));
                exp_tx_data = e.data;
            end
        end
        if (bus.xfer_done) xfer_cnt++;

        if (accepted) begin
            rdy_q     = 1'b0;
            shift_cnt = 3;
            accepted  = 1'b0;
        end else if (shift_cnt > 0) begin
            shift_cnt--;
            if (shift_cnt == 0) rdy_q = 1'b1;
        end
        bus.tx_ready = rdy_q && !tx_stall;
        if (bus.tx_valid && bus.tx_ready && !s_rst) begin
            accepted = 1'b1;
            check("tx_word", 64'(bus.tx_data), 64'(exp_tx_data));
        end
    end

    task automatic do_reset();
        s_rst         = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(negedge clk_100);
        s_rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk_100);
            n++;
        end
        check({name, "_idle"}, 64'(bus.busy), 64'(0));
        @(negedge clk_100);
    endtask

    task automatic hold_for_grants(input int want, input string name);
        int n = 0;
        int g = 0;
        while (g < want && n < 600) begin
            @(negedge clk_100);
            n++;
            if (bus.req_ready != '0) g++;
        end
        bus.req_valid = '0;
        check({name, "_grants"}, 64'(g), 64'(want));
    endtask

    initial begin : wd
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs[8];
        int   xb;
        int   gb;
        int   n;
        int   rot_ids[5];

        vecs[0] = '{4'b0100, 32'h00A5_0000, 2, 8'hA5};
        vecs[1] = '{4'b0100, 32'h005A_0000, 2, 8'h5A};
        vecs[2] = '{4'b1111, 32'h4433_2211, 3, 8'h44};
        vecs[3] = '{4'b0011, 32'h0000_BBAA, 0, 8'hAA};
        vecs[4] = '{4'b1010, 32'hDD00_CC00, 1, 8'hCC};
        vecs[5] = '{4'b1000, 32'hEE00_0000, 3, 8'hEE};
        vecs[6] = '{4'b0001, 32'h0000_00FF, 0, 8'hFF};
        vecs[7] = '{4'b0110, 32'h0080_7F00, 1, 8'h7F};

        s_rst         = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        repeat (3) @(negedge clk_100);
        check("rst_tx_valid",  64'(bus.tx_valid),  64'(0));
        check("rst_tx_data",   64'(bus.tx_data),   64'(0));
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_busy",      64'(bus.busy),      64'(0));
        check("rst_xfer_done", 64'(bus.xfer_done), 64'(0));
        check("rst_grant_id",  64'(bus.grant_id),  64'(0));
        s_rst = 1'b0;
        @(negedge clk_100);

        // Single-word grants applied back to back; round-robin state carries between entries.
        for (int i = 0; i < 8; i++) begin
            push(vecs[i].gid, vecs[i].exp_data);
            xb            = xfer_cnt;
            bus.req_valid = vecs[i].valid;
            bus.req_data  = vecs[i].data;
            @(negedge clk_100);
            bus.req_valid = '0;
            check($sformatf("vec%0d_busy", i),     64'(bus.busy),     64'(1));
            check($sformatf("vec%0d_tx_valid", i), 64'(bus.tx_valid), 64'(1));
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_xfer", i), 64'(xfer_cnt), 64'(xb + 1));
        end

        // All requesters held valid from reset.
`ifdef SPI_ARB_BURST_EN
        rot_ids = '{0, 0, 0, 0, 1};
`else
        rot_ids = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        foreach (rot_ids[k]) push(rot_ids[k], 8'h10 + 8'(rot_ids[k]));
        xb            = xfer_cnt;
        bus.req_data  = 32'h1312_1110;
        bus.req_valid = 4'b1111;
        hold_for_grants(5, "rot");
        wait_idle("rot");
        check("rot_xfer", 64'(xfer_cnt), 64'(xb + 5));

        // Transmitter stalled for ten cycles while a word is offered.
        tx_stall = 1'b1;
        @(negedge clk_100);
        push(1, 8'h5C);
        bus.req_data  = 32'h0000_5C00;
        bus.req_valid = 4'b0010;
        @(negedge clk_100);
        bus.req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_100);
            check("stall_valid", 64'(bus.tx_valid),  64'(1));
            check("stall_data",  64'(bus.tx_data),   64'(8'h5C));
            check("stall_ready", 64'(bus.req_ready), 64'(0));
        end
        tx_stall = 1'b0;
        wait_idle("stall");

        // Reset while waiting for the transmitter to finish.
        push(3, 8'hE7);
        bus.req_data  = 32'hE700_0000;
        bus.req_valid = 4'b1000;
        @(negedge clk_100);
        bus.req_valid = '0;
        n = 0;
        while (!(bus.busy && !bus.tx_valid) && n < 50) begin
            @(negedge clk_100);
            n++;
        end
        check("rstw_in_wait", 64'(bus.busy && !bus.tx_valid), 64'(1));
        xb    = xfer_cnt;
        s_rst = 1'b1;
        @(negedge clk_100);
        check("rstw_busy",      64'(bus.busy),      64'(0));
        check("rstw_tx_valid",  64'(bus.tx_valid),  64'(0));
        check("rstw_xfer_done", 64'(bus.xfer_done), 64'(0));
        check("rstw_grant_id",  64'(bus.grant_id),  64'(0));
        s_rst = 1'b0;
        repeat (8) @(negedge clk_100);
        check("rstw_no_xfer", 64'(xfer_cnt), 64'(xb));
        push(0, 8'hA0);
        bus.req_data  = 32'hD3C2_B1A0;
        bus.req_valid = 4'b1111;
        @(negedge clk_100);
        bus.req_valid = '0;
        wait_idle("rstw");

        // One-cycle request from requester 1 while the arbiter is busy.
        gb = grant_cnt;
        push(0, 8'h77);
        bus.req_data  = 32'h0000_0077;
        bus.req_valid = 4'b0001;
        @(negedge clk_100);
        bus.req_data  = 32'h0000_8800;
        bus.req_valid = 4'b0010;
        @(negedge clk_100);
        bus.req_valid = '0;
        wait_idle("pulse");
        repeat (4) @(negedge clk_100);
        check("pulse_grants", 64'(grant_cnt), 64'(gb + 1));

        // Two requesters held valid: alternation, or four-word bursts when enabled.
        do_reset();
        for (int k = 0; k < 8; k++) begin
`ifdef SPI_ARB_BURST_EN
            push(k / 4, 8'h21 + 8'(k / 4));
`else
            push(k % 2, 8'h21 + 8'(k % 2));
`endif
        end
        xb            = xfer_cnt;
        bus.req_data  = 32'h0000_2221;
        bus.req_valid = 4'b0011;
        hold_for_grants(8, "burst");
        wait_idle("burst");
        check("burst_xfer", 64'(xfer_cnt), 64'(xb + 8));

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter P_DATA_WIDTH, default 8, word width in bits, range 1..32.
REQ-002 Parameter P_NUM_REQ, default 4, number of requesters, range 2..8.
REQ-003 Parameter P_MAX_BURST, default 4, maximum consecutive words per grant, used only when SPI_ARB_BURST_EN is defined.
REQ-004 clk_100  input  1  single system clock; all logic on its rising edge.
REQ-005 s_rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  P_NUM_REQ  per-requester word pending.
REQ-007 req_data  input  P_NUM_REQ*P_DATA_WIDTH  per-requester word; requester i occupies bits [i*W +: W].
REQ-008 req_ready  output  P_NUM_REQ  one-hot, one-cycle pulse: word of requester i accepted this cycle.
REQ-009 tx_valid  output  1  word offered to the transmitter.
REQ-010 tx_data  output  P_DATA_WIDTH  word offered to the transmitter.
REQ-011 tx_ready  input  1  transmitter idle and able to accept a word.
REQ-012 grant_id  output  $clog2(P_NUM_REQ)  index of the current or last granted requester.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 xfer_done  output  1  one-cycle pulse when the transmitter returns ready after a word.

Function
REQ-015 All outputs shall be registered.
REQ-016 FSM states: IDLE, SEND, WAIT.
REQ-017 IDLE: if any req_valid is high, select one round-robin, searching from (last_grant+1) mod P_NUM_REQ upward with wrap-around; capture its data into tx_data, set grant_id, pulse req_ready[grant], go to SEND. Otherwise stay in IDLE.
REQ-018 Latency: req_valid high in IDLE at cycle t -> req_ready pulse and tx_valid high at t+1.
REQ-019 SEND: hold tx_valid and tx_data stable until tx_valid && tx_ready; in that cycle clear tx_valid and go to WAIT.
REQ-020 Transmitter contract: tx_ready is low the cycle after acceptance and stays low until the word has been shifted out.
REQ-021 WAIT: when tx_ready is 1, pulse xfer_done and return to IDLE (or re-grant per REQ-027).
REQ-022 Only one req_ready bit shall ever be high, and only at the moment of capture.
REQ-023 Requesters that deassert req_valid before the grant are skipped; no word is fabricated.
REQ-024 With all requesters valid continuously, grants shall rotate 0,1,...,N-1,0 with no requester starved.

Reset
REQ-025 While s_rst is high: state=IDLE, tx_valid=0, tx_data=0, req_ready=0, busy=0, xfer_done=0, grant_id=0, last_grant=P_NUM_REQ-1 (requester 0 has first priority).
REQ-026 s_rst dominates all other inputs, including mid-SEND or mid-WAIT; the in-flight word is dropped and no xfer_done is issued.

Configuration
REQ-027 Macro SPI_ARB_BURST_EN defined: in WAIT, when tx_ready returns, if req_valid[grant_id] is high and fewer than P_MAX_BURST words have been sent this grant, re-grant the same requester directly (capture, req_ready pulse, go to SEND) without rotating; the burst count resets on rotation.
REQ-028 SPI_ARB_BURST_EN undefined: every grant is exactly one word, burst logic is absent, and P_MAX_BURST is ignored.

Verification
REQ-029 Reset, then req_valid=4'b0100 with data 8'hA5 -> req_ready=4'b0100 one cycle later, tx_valid=1 and tx_data=8'hA5 until tx_ready handshake, grant_id=2.
REQ-030 req_valid=4'b1111 held, words 8'h10..8'h13 -> grant order 0,1,2,3,0; one xfer_done per word.
REQ-031 tx_ready held low for 10 cycles during SEND -> tx_valid and tx_data stable for all 10 cycles; no req_ready pulse.
REQ-032 s_rst asserted in WAIT -> next cycle busy=0, tx_valid=0, no xfer_done; next grant goes to requester 0.
REQ-033 SPI_ARB_BURST_EN defined, P_MAX_BURST=4, req_valid=4'b0011 held -> requester 0 gets 4 words, then requester 1 gets 4; undefined -> 0,1 alternate.
REQ-034 req_valid[1] pulsed for one cycle while busy -> no grant to requester 1 and no req_ready[1] pulse.
